// File: rtl/calc_pkg.sv
// Shared types and BCD shift helpers for the calculator entry path.
// Helpers work on a fixed maximum-width vector; callers cast to their own width.
package calc_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int MAX_SUPPORTED_DIGITS = 16;
  localparam int BCD_VEC_W = BCD_W * MAX_SUPPORTED_DIGITS;

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    RESULT
  } entry_state_t;

  // Shift one digit in at the least-significant end.
  function automatic logic [BCD_VEC_W-1:0] bcd_shl_insert(
    input logic [BCD_VEC_W-1:0] v,
    input logic [BCD_W-1:0]     d
  );
    return {v[BCD_VEC_W-BCD_W-1:0], d};
  endfunction

  // Drop the least-significant digit, zero-filling at the top.
  function automatic logic [BCD_VEC_W-1:0] bcd_shr(
    input logic [BCD_VEC_W-1:0] v
  );
    return {{BCD_W{1'b0}}, v[BCD_VEC_W-1:BCD_W]};
  endfunction

endpackage

// File: rtl/bcd_entry_buffer.sv
// Keypad operand buffer: left-shifting BCD register with backspace, sign,
// result load and sticky error flags. Commands resolve by fixed priority.
module bcd_entry_buffer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 10,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      digit_valid,
  input  logic [BCD_W-1:0]          digit,
  input  logic                      backspace,
  input  logic                      sign_toggle,
  input  logic                      clear,
  input  logic                      load_valid,
  input  logic [BCD_W*MAX_DIGITS-1:0] load_value,
  input  logic [CNT_W-1:0]          load_count,
  input  logic                      load_neg,
  output logic [BCD_W*MAX_DIGITS-1:0] num_bcd,
  output logic [CNT_W-1:0]          digit_count,
  output logic                      negative,
  output logic                      full,
  output logic                      overflow,
  output logic                      bad_digit,
  output logic                      showing_result
);

  localparam int NUM_W = BCD_W * MAX_DIGITS;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  logic [NUM_W-1:0]     r_num,   w_num_next;
  logic [CNT_W-1:0]     r_count, w_count_next;
  logic                 r_neg,   w_neg_next;
  logic                 r_ovf,   w_ovf_next;
  logic                 r_bad,   w_bad_next;
  entry_state_t         r_state, w_state_next;
  logic [BCD_VEC_W-1:0] w_num_ext;

  assign w_num_ext = BCD_VEC_W'(r_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num   <= '0;
      r_count <= '0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
      r_bad   <= 1'b0;
      r_state <= EMPTY;
    end else begin
      r_num   <= w_num_next;
      r_count <= w_count_next;
      r_neg   <= w_neg_next;
      r_ovf   <= w_ovf_next;
      r_bad   <= w_bad_next;
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_num_next   = r_num;
    w_count_next = r_count;
    w_neg_next   = r_neg;
    w_ovf_next   = r_ovf;
    w_bad_next   = r_bad;
    w_state_next = r_state;

    if (clear) begin
      w_num_next   = '0;
      w_count_next = '0;
      w_neg_next   = 1'b0;
      w_ovf_next   = 1'b0;
      w_bad_next   = 1'b0;
      w_state_next = EMPTY;
    end else if (load_valid) begin
      w_num_next   = load_value;
      w_count_next = (load_count > MAX_CNT) ? MAX_CNT : load_count;
      w_neg_next   = load_neg;
      w_ovf_next   = 1'b0;
      w_bad_next   = 1'b0;
      w_state_next = RESULT;
    end else if (backspace) begin
      w_ovf_next = 1'b0;
      case (r_state)
        ENTRY: begin
          w_num_next   = NUM_W'(bcd_shr(w_num_ext));
          w_count_next = r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            w_neg_next   = 1'b0;
            w_state_next = EMPTY;
          end
        end
        RESULT: begin
          w_num_next   = '0;
          w_count_next = '0;
          w_neg_next   = 1'b0;
          w_bad_next   = 1'b0;
          w_state_next = EMPTY;
        end
        default: ;
      endcase
    end else if (digit_valid) begin
      if (digit > BCD_MAX) begin
        w_bad_next = 1'b1;
      end else if (r_state == ENTRY) begin
        if (r_count == MAX_CNT) begin
          w_ovf_next = 1'b1;
        end else begin
          w_num_next   = NUM_W'(bcd_shl_insert(w_num_ext, digit));
          w_count_next = r_count + CNT_W'(1);
        end
      end else if (!(r_state == EMPTY && digit == '0)) begin
        // A fresh digit after a result (or into an empty buffer) starts a new operand.
        w_num_next   = NUM_W'(digit);
        w_count_next = CNT_W'(1);
        w_neg_next   = 1'b0;
        w_state_next = ENTRY;
      end
    end else if (sign_toggle) begin
      if (r_state != EMPTY) begin
        w_neg_next = ~r_neg;
      end
    end
  end

  assign num_bcd        = r_num;
  assign digit_count    = r_count;
  assign negative       = r_neg;
  assign overflow       = r_ovf;
  assign bad_digit      = r_bad;
  assign full           = (r_count == MAX_CNT);
  assign showing_result = (r_state == RESULT);

endmodule
